// File: rtl/phy_lane_config_ctrl.sv
// phy_lane_config_ctrl: collects lane->connection assignment beats, builds the
// per-lane and per-connection lane tables, pulses physical_layer_program_en,
// then tracks link-up of every assigned lane.
// Optional feature macro: PHY_CFG_TIMEOUT_EN (WAIT_UP timeout, error code 3).
module phy_lane_config_ctrl #(
  parameter int NUM_LANES     = 4,
  parameter int LANE_ID_WIDTH = 2,
  parameter int CONN_ID_WIDTH = 2,
  parameter int PROG_CYCLES   = 4,
  parameter int UP_TIMEOUT    = 65535
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [LANE_ID_WIDTH-1:0]                     cfg_lane,
  input  logic [CONN_ID_WIDTH-1:0]                     cfg_conn_id,
  input  logic                                         cfg_last,
  input  logic                                         reconfig,
  input  logic [NUM_LANES-1:0]                         lanes_up,
  output logic [NUM_LANES-1:0][CONN_ID_WIDTH-1:0]      lanes_connection_id,
  output logic [NUM_LANES-1:0][LANE_ID_WIDTH-1:0]      lanes_order_id,
  output logic [NUM_LANES-1:0][NUM_LANES-1:0]          physical_lane_list,
  output logic [NUM_LANES-1:0][LANE_ID_WIDTH:0]        physical_lane_list_count,
  output logic [CONN_ID_WIDTH-1:0]                     num_connections_minus_one,
  output logic                                         physical_layer_program_en,
  output logic                                         connections_ready,
  output logic [1:0]                                   cfg_error,
  output logic [2:0]                                   cfg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_PROGRAM = 3'd2,
    S_WAIT_UP = 3'd3,
    S_READY   = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t                                  state, state_nxt;
  logic [1:0]                              err_nxt;
  logic [NUM_LANES-1:0]                    assigned;
  logic [NUM_LANES-1:0]                    up_q;
  logic                                    rdy_q;
  logic [31:0]                             prog_cnt;
  logic                                    accept, dup, gap, all_up;
  logic [NUM_LANES-1:0][LANE_ID_WIDTH:0]   cnt_nxt;
  logic [CONN_ID_WIDTH-1:0]                max_nxt;

  // reconfig must block a same-cycle beat, so it gates the registered ready
  assign cfg_ready = rdy_q & ~reconfig;
  assign accept    = cfg_valid & cfg_ready;
  assign dup       = assigned[cfg_lane];
  assign all_up    = ((up_q & assigned) == assigned);
  assign cfg_state = state;

  // Counts and max connection id as they will be after this beat, for the gap check
  always_comb begin
    cnt_nxt = physical_lane_list_count;
    max_nxt = num_connections_minus_one;
    if (accept && !dup) begin
      cnt_nxt[cfg_conn_id] = physical_lane_list_count[cfg_conn_id] + 1'b1;
      if (cfg_conn_id > max_nxt) max_nxt = cfg_conn_id;
    end
    gap = 1'b0;
    for (int c = 0; c < NUM_LANES; c++)
      if ((CONN_ID_WIDTH'(c) <= max_nxt) && (cnt_nxt[c] == '0)) gap = 1'b1;
  end

`ifdef PHY_CFG_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;
  assign to_hit = (to_cnt >= 32'(UP_TIMEOUT - 1));

  // Timeout counter: runs only while staying in WAIT_UP, zero elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          to_cnt <= '0;
    else if (state == S_WAIT_UP && state_nxt == S_WAIT_UP) to_cnt <= to_cnt + 1'b1;
    else                                                 to_cnt <= '0;
  end
`else
  logic to_hit;
  logic unused_to;
  assign to_hit    = 1'b0;
  assign unused_to = (UP_TIMEOUT == 0);
`endif

  // Next-state and error-code decode; reconfig overrides everything
  always_comb begin
    state_nxt = state;
    err_nxt   = cfg_error;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (accept) begin
          if (dup) begin
            state_nxt = S_ERROR;
            err_nxt   = 2'd1;
          end else if (cfg_last) begin
            if (gap) begin
              state_nxt = S_ERROR;
              err_nxt   = 2'd2;
            end else begin
              state_nxt = S_PROGRAM;
            end
          end else begin
            state_nxt = S_COLLECT;
          end
        end
      end
      S_PROGRAM: if (prog_cnt == 32'(PROG_CYCLES - 1)) state_nxt = S_WAIT_UP;
      S_WAIT_UP: begin
        if (all_up) state_nxt = S_READY;
        else if (to_hit) begin
          state_nxt = S_ERROR;
          err_nxt   = 2'd3;
        end
      end
      S_READY:  if (!all_up) state_nxt = S_WAIT_UP;
      S_ERROR:  state_nxt = S_ERROR;
      default:  state_nxt = S_IDLE;
    endcase
    if (reconfig) begin
      state_nxt = S_IDLE;
      err_nxt   = 2'd0;
    end
  end

  // State, registered status outputs, program-pulse counter, lane-up sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= S_IDLE;
      cfg_error                 <= 2'd0;
      rdy_q                     <= 1'b1;
      physical_layer_program_en <= 1'b0;
      connections_ready         <= 1'b0;
      prog_cnt                  <= '0;
      up_q                      <= '0;
    end else begin
      state                     <= state_nxt;
      cfg_error                 <= err_nxt;
      rdy_q                     <= (state_nxt == S_IDLE) || (state_nxt == S_COLLECT);
      physical_layer_program_en <= (state_nxt == S_PROGRAM);
      connections_ready         <= (state_nxt == S_READY);
      prog_cnt                  <= (state == S_PROGRAM) ? prog_cnt + 1'b1 : '0;
      up_q                      <= lanes_up;
    end
  end

  // Lane/connection tables: written on an accepted non-duplicate beat, cleared by reconfig
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assigned                  <= '0;
      lanes_connection_id       <= '0;
      lanes_order_id            <= '0;
      physical_lane_list        <= '0;
      physical_lane_list_count  <= '0;
      num_connections_minus_one <= '0;
    end else if (reconfig) begin
      assigned                  <= '0;
      lanes_connection_id       <= '0;
      lanes_order_id            <= '0;
      physical_lane_list        <= '0;
      physical_lane_list_count  <= '0;
      num_connections_minus_one <= '0;
    end else if (accept && !dup) begin
      assigned[cfg_lane]                        <= 1'b1;
      lanes_connection_id[cfg_lane]             <= cfg_conn_id;
      lanes_order_id[cfg_lane]                  <= physical_lane_list_count[cfg_conn_id][LANE_ID_WIDTH-1:0];
      physical_lane_list[cfg_conn_id][cfg_lane] <= 1'b1;
      physical_lane_list_count                  <= cnt_nxt;
      num_connections_minus_one                 <= max_nxt;
    end
  end

endmodule

// File: tb/tb_phy_lane_config_ctrl.sv
// Directed bench for phy_lane_config_ctrl: hand-computed expectations checked
// with immediate assertions at each step.
module tb_phy_lane_config_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid, cfg_ready, cfg_last, reconfig;
  logic [1:0]        cfg_lane, cfg_conn_id;
  logic [3:0]        lanes_up;
  logic [3:0][1:0]   lanes_connection_id, lanes_order_id;
  logic [3:0][3:0]   physical_lane_list;
  logic [3:0][2:0]   physical_lane_list_count;
  logic [1:0]        num_connections_minus_one;
  logic              physical_layer_program_en, connections_ready;
  logic [1:0]        cfg_error;
  logic [2:0]        cfg_state;

  int nvec = 0;
  int nerr = 0;

  phy_lane_config_ctrl #(
    .NUM_LANES(4), .LANE_ID_WIDTH(2), .CONN_ID_WIDTH(2),
    .PROG_CYCLES(4), .UP_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_lane(cfg_lane), .cfg_conn_id(cfg_conn_id), .cfg_last(cfg_last),
    .reconfig(reconfig), .lanes_up(lanes_up),
    .lanes_connection_id(lanes_connection_id), .lanes_order_id(lanes_order_id),
    .physical_lane_list(physical_lane_list),
    .physical_lane_list_count(physical_lane_list_count),
    .num_connections_minus_one(num_connections_minus_one),
    .physical_layer_program_en(physical_layer_program_en),
    .connections_ready(connections_ready),
    .cfg_error(cfg_error), .cfg_state(cfg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One assignment beat, presented from a negedge and held across one posedge
  task automatic beat(input int lane, input int conn, input bit last);
    cfg_valid   = 1'b1;
    cfg_lane    = 2'(lane);
    cfg_conn_id = 2'(conn);
    cfg_last    = last;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Pulse reconfig for one edge (starting at a negedge), then check the cleared state
  task automatic do_reconfig(input string tag);
    reconfig = 1'b1;
    #1;
    chk({tag, " ready_blocked"}, 32'(cfg_ready), 32'd0);
    @(posedge clk);
    #1;
    reconfig = 1'b0;
    step();
    chk({tag, " state_idle"}, 32'(cfg_state), 32'd0);
    chk({tag, " err_clr"}, 32'(cfg_error), 32'd0);
    chk({tag, " lists_zero"}, 32'(physical_lane_list), 32'd0);
    chk({tag, " counts_zero"}, 32'(physical_lane_list_count), 32'd0);
    chk({tag, " ids_zero"}, {16'd0, 8'(lanes_connection_id), 8'(lanes_order_id)}, 32'd0);
    chk({tag, " ready_back"}, 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_lane = '0; cfg_conn_id = '0;
    cfg_last = 1'b0; reconfig = 1'b0; lanes_up = '0;
    #12;
    // reset values
    chk("rst cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst state", 32'(cfg_state), 32'd0);
    chk("rst outputs", {28'd0, physical_layer_program_en, connections_ready, cfg_error}, 32'd0);
    chk("rst lists", 32'(physical_lane_list), 32'd0);
    rst_n = 1'b1;
    step();

    // Two connections of two lanes each
    beat(0, 0, 0); beat(1, 0, 0); beat(2, 1, 0); beat(3, 1, 1);
    step();
    chk("cfg1 pe t+1", 32'(physical_layer_program_en), 32'd1);
    chk("cfg1 state prog", 32'(cfg_state), 32'd2);
    chk("cfg1 counts", 32'(physical_lane_list_count), 32'h0012);
    chk("cfg1 lists", 32'(physical_lane_list), 32'h00C3);
    chk("cfg1 order", 32'(lanes_order_id), 32'h44);
    chk("cfg1 connid", 32'(lanes_connection_id), 32'h50);
    chk("cfg1 nconn", 32'(num_connections_minus_one), 32'd1);
    chk("cfg1 ready_low", 32'(cfg_ready), 32'd0);
    step(); chk("cfg1 pe t+2", 32'(physical_layer_program_en), 32'd1);
    step(); chk("cfg1 pe t+3", 32'(physical_layer_program_en), 32'd1);
    step(); chk("cfg1 pe t+4", 32'(physical_layer_program_en), 32'd1);
    step();
    chk("cfg1 pe t+5", 32'(physical_layer_program_en), 32'd0);
    chk("cfg1 wait_up", 32'(cfg_state), 32'd3);
    lanes_up = 4'b1111;
    step(); chk("up +1", 32'(connections_ready), 32'd0);
    step(); chk("up +2", 32'(connections_ready), 32'd1);
    chk("up state", 32'(cfg_state), 32'd4);

    // Lane 2 drops, then recovers
    lanes_up = 4'b1011;
    step(); chk("drop +1", 32'(connections_ready), 32'd1);
    step(); chk("drop +2", 32'(connections_ready), 32'd0);
    chk("drop state", 32'(cfg_state), 32'd3);
    lanes_up = 4'b1111;
    step(); chk("recov +1", 32'(connections_ready), 32'd0);
    step(); chk("recov +2", 32'(connections_ready), 32'd1);
    do_reconfig("rc1");
    chk("rc1 cr_low", 32'(connections_ready), 32'd0);
    lanes_up = 4'b0000;

    // Duplicate lane
    beat(1, 0, 0); beat(1, 1, 0);
    step();
    chk("dup err", 32'(cfg_error), 32'd1);
    chk("dup state", 32'(cfg_state), 32'd5);
    chk("dup list", 32'(physical_lane_list), 32'h0002);
    chk("dup connid", 32'(lanes_connection_id), 32'h00);
    step(); chk("dup no_pe", 32'(physical_layer_program_en), 32'd0);
    do_reconfig("rc2");

    // Duplicate on the last beat: no program pulse
    beat(2, 0, 0); beat(2, 0, 1);
    step(); chk("duplast err", 32'(cfg_error), 32'd1);
    chk("duplast no_pe", 32'(physical_layer_program_en), 32'd0);
    step(); chk("duplast state", 32'(cfg_state), 32'd5);
    do_reconfig("rc3");

    // Connection-id gap
    beat(0, 0, 0); beat(1, 2, 1);
    step();
    chk("gap err", 32'(cfg_error), 32'd2);
    chk("gap state", 32'(cfg_state), 32'd5);
    chk("gap nconn", 32'(num_connections_minus_one), 32'd2);
    chk("gap counts", 32'(physical_lane_list_count), 32'h0041);
    chk("gap no_pe", 32'(physical_layer_program_en), 32'd0);
    step(); chk("gap latched", 32'(cfg_error), 32'd2);
    do_reconfig("rc4");

    // reconfig together with a beat: beat dropped
    cfg_valid = 1'b1; cfg_lane = 2'd3; cfg_conn_id = 2'd0; cfg_last = 1'b1;
    reconfig = 1'b1;
    #1; chk("rcbeat ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_last = 1'b0; reconfig = 1'b0;
    step();
    chk("rcbeat state", 32'(cfg_state), 32'd0);
    chk("rcbeat list", 32'(physical_lane_list), 32'd0);

    // reconfig on cycle 2 of the program pulse
    beat(0, 0, 1);
    step(); chk("trunc pe1", 32'(physical_layer_program_en), 32'd1);
    step(); chk("trunc pe2", 32'(physical_layer_program_en), 32'd1);
    reconfig = 1'b1;
    @(posedge clk); #1; reconfig = 1'b0;
    step();
    chk("trunc pe_off", 32'(physical_layer_program_en), 32'd0);
    chk("trunc state", 32'(cfg_state), 32'd0);

    // Asynchronous reset mid-pulse
    beat(3, 0, 1);
    step(); chk("arst pe_on", 32'(physical_layer_program_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst pe", 32'(physical_layer_program_en), 32'd0);
    chk("arst state", 32'(cfg_state), 32'd0);
    chk("arst ready", 32'(cfg_ready), 32'd1);
    chk("arst list", 32'(physical_lane_list), 32'd0);
    step(); rst_n = 1'b1;
    step();

    // WAIT_UP with lanes_up held low
    beat(0, 0, 1);
    repeat (5) step();
    chk("wu entry", 32'(cfg_state), 32'd3);
`ifdef PHY_CFG_TIMEOUT_EN
    repeat (15) step();
    chk("to before", 32'(cfg_state), 32'd3);
    chk("to err_before", 32'(cfg_error), 32'd0);
    step();
    chk("to state", 32'(cfg_state), 32'd5);
    chk("to err", 32'(cfg_error), 32'd3);
    chk("to cr", 32'(connections_ready), 32'd0);
`else
    repeat (40) step();
    chk("wu hold state", 32'(cfg_state), 32'd3);
    chk("wu hold err", 32'(cfg_error), 32'd0);
    chk("wu hold cr", 32'(connections_ready), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
